sram_stream_loader: RTL and testbench

- Writer-side front end for the 2R1W SRAM banks that the compute Top reads as its inputs.
- Accepts a valid/ready stream of 128-bit words and writes each word into both input banks, M1 and M3, at consecutive addresses.
- Once the whole image is written, raises a level `start` for Top.
- Replaces the bench-only `$readmemh` preload with synthesizable loading.

---
 rtl/sram_stream_loader.sv | 142 ++++++++++++++
 tb/tb_sram_stream_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_loader.sv
// Streams DATA_WIDTH words into input banks M1 and M3 at consecutive addresses, then raises start for Top.
// Optional running lane-XOR checksum of the loaded image is enabled with `define LOADER_CHECKSUM_EN.
module sram_stream_loader #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  M1_WriteEnable,
    output logic [ADDR_WIDTH-1:0] M1_WriteAddress,
    output logic [DATA_WIDTH-1:0] M1_WriteBus,
    output logic                  M3_WriteEnable,
    output logic [ADDR_WIDTH-1:0] M3_WriteAddress,
    output logic [DATA_WIDTH-1:0] M3_WriteBus,
    output logic                  start,
    output logic                  busy,
    output logic                  load_done,
    output logic [31:0]           checksum
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic                  rdy_q, rdy_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] bus_q, bus_d;
    logic                  accept;
    logic                  req_ok;

    assign accept = rdy_q && in_valid;
    assign req_ok = load_req && (load_len != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        bus_d   = bus_q;
        case (state_q)
            IDLE, DONE: begin
                if (req_ok) begin
                    state_d = LOAD;
                    len_d   = load_len;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    we_d   = 1'b1;
                    addr_d = BASE_ADDR + cnt_q;
                    bus_d  = in_data;
                    cnt_d  = cnt_q + ONE;
                    if (cnt_q == len_q - ONE) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        // Ready is registered off the next state so it drops right after the final beat.
        rdy_d = (state_d == LOAD);
    end

    assign in_ready        = rdy_q;
    assign M1_WriteEnable  = we_q;
    assign M1_WriteAddress = addr_q;
    assign M1_WriteBus     = bus_q;
    assign M3_WriteEnable  = we_q;
    assign M3_WriteAddress = addr_q;
    assign M3_WriteBus     = bus_q;
    assign start           = (state_q == DONE);
    assign busy            = (state_q == LOAD) || (state_q == FLUSH);
    assign load_done       = (state_q == FLUSH);

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] chk_q, chk_d;

    function automatic logic [31:0] lane_fold(input logic [DATA_WIDTH-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < DATA_WIDTH / 32; i++) begin
            f = f ^ d[i*32 +: 32];
        end
        return f;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    always_comb begin
        chk_d = chk_q;
        if (((state_q == IDLE) || (state_q == DONE)) && req_ok) begin
            chk_d = '0;
        end else if (accept) begin
            chk_d = chk_q ^ lane_fold(in_data);
        end
    end

    assign checksum = chk_q;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_sram_stream_loader.sv
// Bench for sram_stream_loader: two instances (base 0 and base FFFE) share one stimulus stream
// and are compared every cycle against a transaction-level model of the load protocol.
module tb_sram_stream_loader;

    localparam logic [15:0] BASE_A = 16'h0000;
    localparam logic [15:0] BASE_B = 16'hFFFE;

    logic         clock = 1'b0;
    logic         reset;
    logic         load_req;
    logic [15:0]  load_len;
    logic         in_valid;
    logic [127:0] in_data;

    logic a_rdy, a_we1, a_we3, a_start, a_busy, a_done;
    logic [15:0] a_ad1, a_ad3;
    logic [127:0] a_bus1, a_bus3;
    logic [31:0] a_chk;
    logic b_rdy, b_we1, b_we3, b_start, b_busy, b_done;
    logic [15:0] b_ad1, b_ad3;
    logic [127:0] b_bus1, b_bus3;
    logic [31:0] b_chk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model of the load protocol: beats accepted so far out of the requested length.
    bit           m_active, m_complete;
    int           m_cnt, m_len;
    logic         e_we;
    logic [15:0]  e_addr_a, e_addr_b;
    logic [127:0] e_bus;
    logic [31:0]  m_chk;

    always #5 clock = ~clock;

    sram_stream_loader #(.DATA_WIDTH(128), .ADDR_WIDTH(16), .BASE_ADDR(BASE_A)) dut_a (
        .clock(clock), .reset(reset), .load_req(load_req), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_rdy),
        .M1_WriteEnable(a_we1), .M1_WriteAddress(a_ad1), .M1_WriteBus(a_bus1),
        .M3_WriteEnable(a_we3), .M3_WriteAddress(a_ad3), .M3_WriteBus(a_bus3),
        .start(a_start), .busy(a_busy), .load_done(a_done), .checksum(a_chk)
    );

    sram_stream_loader #(.DATA_WIDTH(128), .ADDR_WIDTH(16), .BASE_ADDR(BASE_B)) dut_b (
        .clock(clock), .reset(reset), .load_req(load_req), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_rdy),
        .M1_WriteEnable(b_we1), .M1_WriteAddress(b_ad1), .M1_WriteBus(b_bus1),
        .M3_WriteEnable(b_we3), .M3_WriteAddress(b_ad3), .M3_WriteBus(b_bus3),
        .start(b_start), .busy(b_busy), .load_done(b_done), .checksum(b_chk)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_complete = 0; m_cnt = 0; m_len = 0;
        e_we = 0; e_addr_a = '0; e_addr_b = '0; e_bus = '0; m_chk = '0;
    endtask

    function automatic logic [31:0] fold4(input logic [127:0] d);
        return d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
    endfunction

    task automatic model_edge();
        logic nwe;
        nwe = 1'b0;
        if (m_active && m_cnt < m_len) begin
            if (in_valid) begin
                nwe      = 1'b1;
                e_addr_a = BASE_A + 16'(m_cnt);
                e_addr_b = BASE_B + 16'(m_cnt);
                e_bus    = in_data;
                m_chk    = m_chk ^ fold4(in_data);
                m_cnt++;
            end
        end else if (m_active) begin
            m_active   = 0;
            m_complete = 1;
        end else if (load_req && load_len != 0) begin
            m_active   = 1;
            m_complete = 0;
            m_cnt      = 0;
            m_len      = load_len;
            m_chk      = '0;
        end
        e_we = nwe;
    endtask

    task automatic check_all();
        logic        x_rdy, x_busy, x_done, x_start;
        logic [31:0] x_chk;
        x_rdy   = m_active && (m_cnt < m_len);
        x_busy  = m_active;
        x_done  = m_active && (m_cnt == m_len);
        x_start = m_complete && !m_active;
`ifdef LOADER_CHECKSUM_EN
        x_chk = m_chk;
`else
        x_chk = 32'h0;
`endif
        check_eq("a_ready", a_rdy, x_rdy);     check_eq("b_ready", b_rdy, x_rdy);
        check_eq("a_busy", a_busy, x_busy);    check_eq("b_busy", b_busy, x_busy);
        check_eq("a_done", a_done, x_done);    check_eq("b_done", b_done, x_done);
        check_eq("a_start", a_start, x_start); check_eq("b_start", b_start, x_start);
        check_eq("a_we1", a_we1, e_we);        check_eq("a_we3", a_we3, e_we);
        check_eq("b_we1", b_we1, e_we);        check_eq("b_we3", b_we3, e_we);
        check_eq("a_addr1", a_ad1, e_addr_a);  check_eq("a_addr3", a_ad3, e_addr_a);
        check_eq("b_addr1", b_ad1, e_addr_b);  check_eq("b_addr3", b_ad3, e_addr_b);
        check_eq("a_bus1", a_bus1, e_bus);     check_eq("a_bus3", a_bus3, e_bus);
        check_eq("b_bus1", b_bus1, e_bus);     check_eq("b_bus3", b_bus3, e_bus);
        check_eq("a_chk", a_chk, x_chk);       check_eq("b_chk", b_chk, x_chk);
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic cycle(input logic req, input logic [15:0] len, input logic v, input logic [127:0] d);
        load_req = req; load_len = len; in_valid = v; in_data = d;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic idle_until_quiet(input int budget);
        int n;
        n = 0;
        while (m_active && n < budget) begin
            cycle(1'b0, 16'd0, 1'b0, '0);
            n++;
        end
        if (m_active) check_eq("quiet_timeout", 1'b1, 1'b0);
    endtask

    initial begin
        logic [127:0] w;
        int           n;
        reset = 1'b1; load_req = 0; load_len = 0; in_valid = 0; in_data = '0;
        model_reset();
        #2;
        check_all();
        @(negedge clock);
        check_all();
        reset = 1'b0;

        // Basic back-to-back load of 4 words.
        cycle(1, 16'd4, 0, '0);
        for (int i = 1; i <= 4; i++) cycle(0, 16'd0, 1, 128'(i) | 128'h1234_0000_0000_0000_0000_0000_0000_0000);
        idle_until_quiet(10);
        cycle(0, 16'd0, 0, '0);

        // Backpressure gaps from DONE, with a stray load_req during LOAD.
        cycle(1, 16'd3, 0, '0);
        cycle(0, 16'd0, 1, 128'hAAAA);
        cycle(1, 16'd9, 0, 128'hDEAD);
        cycle(0, 16'd0, 0, 128'hBEEF);
        cycle(0, 16'd0, 1, 128'hBBBB);
        cycle(0, 16'd0, 0, 128'hF00D);
        cycle(0, 16'd0, 1, 128'hCCCC);
        idle_until_quiet(10);

        // Zero-length request in DONE is ignored; in_valid outside LOAD is ignored.
        cycle(1, 16'd0, 1, 128'h5555);
        cycle(0, 16'd0, 1, 128'h6666);

        // Reload of 2 words with checksum lane patterns.
        cycle(1, 16'd2, 0, '0);
        cycle(0, 16'd0, 1, 128'h00000001_00000002_00000004_00000008);
        cycle(0, 16'd0, 1, 128'h10000000_20000000_40000000_80000000);
        idle_until_quiet(10);
        cycle(0, 16'd0, 0, '0);

        // Asynchronous reset after 3 of 8 beats.
        cycle(1, 16'd8, 0, '0);
        for (int i = 0; i < 3; i++) cycle(0, 16'd0, 1, {4{$urandom}});
        load_req = 0; in_valid = 0;
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        #1 reset = 1'b0;
        @(negedge clock);
        check_all();
        cycle(1, 16'd2, 0, '0);
        cycle(0, 16'd0, 1, 128'h77);
        cycle(0, 16'd0, 1, 128'h88);
        idle_until_quiet(10);

        // Randomized loads with random valid gaps, stray requests and zero-length requests.
        for (int k = 0; k < 30; k++) begin
            cycle(1, 16'($urandom_range(1, 12)), $urandom_range(0, 1), {4{$urandom}});
            n = 0;
            while (m_active && n < 200) begin
                w = {$urandom, $urandom, $urandom, $urandom};
                cycle($urandom_range(0, 7) == 0, 16'($urandom_range(0, 5)),
                      $urandom_range(0, 9) < 6, w);
                n++;
            end
            if (m_active) check_eq("load_timeout", 1'b1, 1'b0);
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) cycle(1'b0, 16'd0, $urandom_range(0, 1), {4{$urandom}});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
